pacman_move_controller: RTL

- Downstream consumer of valid_move_detector: takes its one-hot valid_moves for the character's current pixel position and advances that position on each movement tick.
- Buffers the player or AI turn request, applies it only when legal at a tile-aligned position, handles horizontal tunnel wrap-around, and stops at walls.
- Its pos_x/pos_y outputs feed back to valid_move_detector curr_pos_x/curr_pos_y and to the renderer.
- One instance per character (pacman, each ghost).

---
 rtl/pacman_move_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pacman_move_controller.sv
// Per-character movement controller: buffers turn requests, steps on move ticks, wraps horizontally.
// Optional pre-turn buffering is enabled with `define TURN_BUFFER_EN.
module pacman_move_controller #(
  parameter int TILE_W   = 8,
  parameter int STEP     = 1,
  parameter int MAP_W_PX = 640,
  parameter int START_X  = 320,
  parameter int START_Y  = 368,
  parameter int RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_tick,
  input  logic [3:0]  dir_req,
  input  logic [3:0]  valid_moves,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic [3:0]  cur_dir,
  output logic        step_done
);

  localparam logic [3:0] DIR_R = 4'b0001;
  localparam logic [3:0] DIR_U = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0100;
  localparam logic [3:0] DIR_L = 4'b1000;

  localparam int               CNT_W    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
  localparam logic [10:0]      X_MASK   = 11'(TILE_W - 1);
  localparam logic [9:0]       Y_MASK   = 10'(TILE_W - 1);
  localparam logic [10:0]      X_STEP   = 11'(STEP);
  localparam logic [10:0]      X_LAST   = 11'(MAP_W_PX - STEP);
  localparam logic [9:0]       Y_STEP   = 10'(STEP);

  typedef enum logic {SETTLE, READY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       pend_dir, pend_next, pend_eff, dir_next;
  logic             tick_pend, tick_pend_next;
  logic [10:0]      x_next;
  logic [9:0]       y_next;
  logic             done_next;
  logic             aligned;

  // Mirror the one-hot bits: right<->left, up<->down.
  function automatic logic [3:0] reverse_dir(input logic [3:0] d);
    return {d[0], d[1], d[2], d[3]};
  endfunction

  // A fresh legal request takes part in the same cycle's decision.
  assign pend_eff = $onehot(dir_req) ? dir_req : pend_dir;
  assign aligned  = ((pos_x & X_MASK) == '0) && ((pos_y & Y_MASK) == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    state_next     = state;
    cnt_next       = cnt;
    pend_next      = pend_eff;
    tick_pend_next = tick_pend;
    dir_next       = cur_dir;
    x_next         = pos_x;
    y_next         = pos_y;
    done_next      = 1'b0;

    unique case (state)
      SETTLE: begin
        if (move_tick) tick_pend_next = 1'b1;
        if (cnt == '0) state_next = READY;
        else           cnt_next   = cnt - 1'b1;
      end
      READY: begin
        if (move_tick || tick_pend) begin
          tick_pend_next = 1'b0;
          if (aligned) begin
            if ((pend_eff & valid_moves) != 4'b0000) begin
              dir_next  = pend_eff;
              pend_next = 4'b0000;
            end else if ((cur_dir & valid_moves) == 4'b0000) begin
              dir_next = 4'b0000;
            end
`ifdef TURN_BUFFER_EN
            // An untaken request stays buffered for a later decision point.
`else
            pend_next = 4'b0000;
`endif
          end else if (cur_dir != 4'b0000 && pend_eff == reverse_dir(cur_dir)) begin
            dir_next  = pend_eff;
            pend_next = 4'b0000;
          end

          if (dir_next == DIR_U && pos_y < Y_STEP) dir_next = 4'b0000;

          if (dir_next != 4'b0000) begin
            done_next  = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = SETTLE;
            case (dir_next)
              DIR_R:   x_next = (pos_x == X_LAST) ? 11'd0 : pos_x + X_STEP;
              DIR_L:   x_next = (pos_x == 11'd0) ? X_LAST : pos_x - X_STEP;
              DIR_U:   y_next = pos_y - Y_STEP;
              DIR_D:   y_next = pos_y + Y_STEP;
              default: ;
            endcase
          end
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SETTLE;
      cnt       <= CNT_LOAD;
      pend_dir  <= 4'b0000;
      tick_pend <= 1'b0;
      cur_dir   <= 4'b0000;
      pos_x     <= 11'(START_X);
      pos_y     <= 10'(START_Y);
      step_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pend_dir  <= pend_next;
      tick_pend <= tick_pend_next;
      cur_dir   <= dir_next;
      pos_x     <= x_next;
      pos_y     <= y_next;
      step_done <= done_next;
    end
  end

endmodule
